jtframe_sdram64_slots: RTL

- Read-only arbiter that shares one bank port of the 64-bit-burst SDRAM controller among four 16-bit requesters ("slots"), e.g. CPU ROM, tile, sprite and sound ROM fetches.
- Grants are round-robin; each grant issues one 4-beat (64-bit) burst and assembles the beats into a line.
- Returns the addressed 16-bit word to the requesting slot.
- Sits between game-side ROM clients and a single bank's addr/rd/ack/dst/dok/rdy/dout interface.

---
 rtl/jtframe_sdram64_slots_pkg.sv | 35 +++
 rtl/jtframe_sdram64_slot_line.sv | 100 ++++++++++
 rtl/jtframe_sdram64_slots.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/jtframe_sdram64_slots_pkg.sv
// Shared types for the four-slot SDRAM read arbiter.
//
// Contents:
//   state_t   arbiter FSM state encoding (IDLE, WAIT_ACK, DATA, DONE)
//   BEATS     beats per burst (16-bit beats, 64-bit line)
//   NSLOTS    slot count this version is built for
//   line_t    one assembled burst line, word n holds beat n
//   tag_w()   tag width for a given word-address width
//   rr_inc()  round-robin pointer advance with wrap 3 -> 0
package jtframe_sdram64_slots_pkg;

    localparam int DEF_AW = 22;
    localparam int NSLOTS = 4;
    localparam int BEATS  = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        DATA     = 2'd2,
        DONE     = 2'd3
    } state_t;

    typedef logic [BEATS-1:0][15:0] line_t;

    // A line covers BEATS words, so the two low address bits select the word
    // and the rest form the tag.
    function automatic int tag_w(input int aw);
        return aw - 2;
    endfunction

    function automatic logic [1:0] rr_inc(input logic [1:0] ptr);
        return ptr + 2'd1;
    endfunction

endpackage

// File: rtl/jtframe_sdram64_slot_line.sv
// Per-slot line buffer: holds the last line fetched for one slot (tag, valid,
// four words) and produces that slot's registered ok/data outputs.
//
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   cs          slot request level
//   eff         effective word address of the slot (address + offset)
//   wr          one-cycle strobe: the arbiter finished a burst for this slot
//   wr_tag      tag of the finished burst
//   wr_line     data of the finished burst
//   ok, dout    slot data valid / data word
//   hit         slot address is served from the stored line (cache build only,
//               tied low otherwise) so the arbiter must not request it
//
// Build option: JTFRAME_SLOT_CACHE_EN keeps the stored line as a one-line cache.
// Without it the stored line only serves the burst that just completed and
// the word held under ok; any address change drops ok.
module jtframe_sdram64_slot_line
    import jtframe_sdram64_slots_pkg::*;
#(
    parameter int AW = DEF_AW
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs,
    input  logic [AW-1:0] eff,
    input  logic          wr,
    input  logic [AW-3:0] wr_tag,
    input  line_t         wr_line,
    output logic          ok,
    output logic [15:0]   dout,
    output logic          hit
);

    logic [AW-3:0] tag;
    logic          valid;
    line_t         line;
    logic [1:0]    word;
    logic          new_match;
    logic          tag_hit;
    logic          keep;
    logic          ok_nxt;
    logic [15:0]   dout_nxt;

    assign word      = eff[1:0];
    // The just-finished burst is compared directly, since the buffer only
    // takes it at the end of this cycle.
    assign new_match = wr && cs && (wr_tag == eff[AW-1:2]);
    assign tag_hit   = cs && valid && (tag == eff[AW-1:2]);

`ifdef JTFRAME_SLOT_CACHE_EN
    assign hit  = tag_hit;
    assign keep = tag_hit;
`else
    logic [1:0] ok_word;

    assign hit  = 1'b0;
    // ok is only held for the exact word it was raised for.
    assign keep = ok && tag_hit && (word == ok_word);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ok_word <= 2'd0;
        end else if (new_match) begin
            ok_word <= word;
        end
    end
`endif

    always_comb begin
        ok_nxt   = 1'b0;
        dout_nxt = dout;
        if (new_match) begin
            ok_nxt   = 1'b1;
            dout_nxt = wr_line[word];
        end else if (keep) begin
            ok_nxt   = 1'b1;
            dout_nxt = line[word];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag   <= '0;
            valid <= 1'b0;
            line  <= '0;
            ok    <= 1'b0;
            dout  <= 16'd0;
        end else begin
            ok   <= ok_nxt;
            dout <= dout_nxt;
            if (wr) begin
                tag   <= wr_tag;
                valid <= 1'b1;
                line  <= wr_line;
            end
        end
    end

endmodule

// File: rtl/jtframe_sdram64_slots.sv
// Read-only arbiter sharing one 64-bit-burst SDRAM bank port among four
// 16-bit ROM clients. Round-robin grant, one 4-beat burst per grant, beats
// assembled into a line and the addressed word returned to the slot.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   slot_cs           per-slot request level, held until slot_ok
//   slot_addr         per-slot word address, slot n at [n*AW +: AW]
//   slot_ok           per-slot data valid for the current address
//   slot_dout         per-slot data word, slot n at [n*16 +: 16]
//   sdram_addr        line address to the bank port (bits [1:0] zero)
//   sdram_rd          read request, held until sdram_ack
//   sdram_ack         request accepted (pulse)
//   sdram_dst         first beat present (pulse)
//   sdram_dok         beat valid
//   sdram_rdy         burst finished (pulse after last beat)
//   sdram_dout        beat data
//   st_dbg            current arbiter state
//
// Handshake: sdram_rd rises with a stable sdram_addr and both hold until the
// cycle sdram_ack is sampled high; beats are taken on sdram_dok only while a
// burst is owned (DATA state); sdram_rdy closes the burst.
//
// Build option: JTFRAME_SLOT_CACHE_EN (see jtframe_sdram64_slot_line).
module jtframe_sdram64_slots
    import jtframe_sdram64_slots_pkg::*;
#(
    parameter int          AW           = DEF_AW,
    parameter int          SW           = NSLOTS,
    parameter logic [AW-1:0] SLOT0_OFFSET = '0,
    parameter logic [AW-1:0] SLOT1_OFFSET = '0,
    parameter logic [AW-1:0] SLOT2_OFFSET = '0,
    parameter logic [AW-1:0] SLOT3_OFFSET = '0
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SW-1:0]    slot_cs,
    input  logic [SW*AW-1:0] slot_addr,
    output logic [SW-1:0]    slot_ok,
    output logic [SW*16-1:0] slot_dout,
    output logic [AW-1:0]    sdram_addr,
    output logic             sdram_rd,
    input  logic             sdram_ack,
    input  logic             sdram_dst,
    input  logic             sdram_dok,
    input  logic             sdram_rdy,
    input  logic [15:0]      sdram_dout,
    output state_t           st_dbg
);

    localparam int TW = tag_w(AW);
    localparam logic [4*AW-1:0] OFFSETS =
        {SLOT3_OFFSET, SLOT2_OFFSET, SLOT1_OFFSET, SLOT0_OFFSET};

    state_t        state, state_nxt;
    logic [1:0]    rr;
    logic [1:0]    gnt;
    logic [1:0]    pick;
    logic          pick_vld;
    logic [TW-1:0] gnt_tag;
    line_t         line_buf;
    logic [2:0]    beat_cnt;
    logic [2:0]    beat_idx;
    logic          beat_wr;
    logic [AW-1:0] eff [SW];
    logic [SW-1:0] req;
    logic [SW-1:0] hit;
    logic [SW-1:0] wr;

    assign st_dbg = state;

    for (genvar n = 0; n < SW; n++) begin : g_slot
        // Offset add wraps modulo 2^AW by width truncation.
        assign eff[n] = slot_addr[n*AW +: AW] + OFFSETS[n*AW +: AW];
        assign wr[n]  = (state == DONE) && (gnt == 2'(n));
        assign req[n] = slot_cs[n] && !slot_ok[n] && !hit[n];

        jtframe_sdram64_slot_line #(
            .AW (AW)
        ) u_line (
            .clk     (clk),
            .rst_n   (rst_n),
            .cs      (slot_cs[n]),
            .eff     (eff[n]),
            .wr      (wr[n]),
            .wr_tag  (gnt_tag),
            .wr_line (line_buf),
            .ok      (slot_ok[n]),
            .dout    (slot_dout[n*16 +: 16]),
            .hit     (hit[n])
        );
    end

    // First pending slot at or after the rr pointer, wrapping 3 -> 0.
    always_comb begin
        pick     = 2'd0;
        pick_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!pick_vld && req[rr + 2'(i)]) begin
                pick     = rr + 2'(i);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (pick_vld)  state_nxt = WAIT_ACK;
            WAIT_ACK: if (sdram_ack) state_nxt = DATA;
            DATA:     if (sdram_rdy) state_nxt = DONE;
            DONE:                    state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // sdram_dst restarts the beat sequence in the same cycle it arrives.
    // beat_cnt counts stored beats and stops at BEATS, so a fifth or later
    // beat (or a stream without sdram_dst) never overwrites the line.
    assign beat_idx = sdram_dst ? 3'd0 : beat_cnt;
    assign beat_wr  = (state == DATA) && sdram_dok && (beat_idx < 3'(BEATS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr         <= 2'd0;
            gnt        <= 2'd0;
            gnt_tag    <= '0;
            sdram_rd   <= 1'b0;
            sdram_addr <= '0;
            beat_cnt   <= 3'd0;
            line_buf   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt        <= pick;
                        gnt_tag    <= eff[pick][AW-1:2];
                        sdram_addr <= {eff[pick][AW-1:2], 2'b00};
                        sdram_rd   <= 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (sdram_ack) begin
                        sdram_rd <= 1'b0;
                        rr       <= rr_inc(gnt);
                        beat_cnt <= 3'd0;
                    end
                end
                DATA: begin
                    if (beat_wr) begin
                        line_buf[beat_idx[1:0]] <= sdram_dout;
                        beat_cnt                <= beat_idx + 3'd1;
                    end else if (sdram_dst) begin
                        beat_cnt <= 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
